// File: rtl/data_memory.sv
// Word-organised data memory: byte address in, 32-bit word out, synchronous store, combinational load.
// Optional suppressed-store counter enabled by defining DMEM_ERR_COUNT_EN.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] read_data,
    output logic              misaligned,
    output logic              out_of_range
`ifdef DMEM_ERR_COUNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // One bit wider than the address so the limit never truncates.
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              write_ok;

    assign word_idx     = address[IDX_W+1:2];
    assign misaligned   = (address[1:0] != 2'b00);
    assign out_of_range = ({1'b0, address} >= BYTE_LIMIT);
    assign write_ok     = write_enable && !misaligned && !out_of_range;
    assign read_data    = out_of_range ? '0 : mem_q[word_idx];

    // Reset clears the whole array and takes priority over a store in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_ok) begin
            mem_q[word_idx] <= write_data;
        end
    end

`ifdef DMEM_ERR_COUNT_EN
    logic [15:0] err_count_q;
    logic [15:0] err_count_d;
    logic        write_suppressed;

    assign write_suppressed = write_enable && (misaligned || out_of_range);

    always_comb begin
        err_count_d = err_count_q;
        if (write_suppressed && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expectations.
// Covers the optional counter when DMEM_ERR_COUNT_EN is defined.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic        misaligned;
    logic        out_of_range;
`ifdef DMEM_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    data_memory #(.DEPTH_WORDS(256), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
`ifdef DMEM_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a store, let one rising edge pass, then drop the strobe.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp,
                              input logic exp_mis, input logic exp_oor);
        address = a;
        #1;
        check({tag, "_data"}, read_data, exp);
        check({tag, "_mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
        check({tag, "_oor"}, {31'b0, out_of_range}, {31'b0, exp_oor});
    endtask

    initial begin
        // Initial reset clears all words.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load_check("rst_w0", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        load_check("rst_w1", 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0);
        load_check("rst_top", 32'h0000_03FC, 32'h0000_0000, 1'b0, 1'b0);
`ifdef DMEM_ERR_COUNT_EN
        check("cnt_rst", {16'b0, err_count}, 32'd0);
`endif

        store(32'h0000_0000, 32'h1234_5678);
        load_check("wr_rd0", 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0);

        // Misaligned store: flag visible before the edge, memory untouched after it.
        address      = 32'h0000_0006;
        write_data   = 32'hDEAD_BEEF;
        write_enable = 1'b1;
        #1;
        check("mis_wr_flag", {31'b0, misaligned}, 32'd1);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        load_check("mis_wr_w1", 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0);

        store(32'h0000_0000, 32'hA5A5_A5A5);
        load_check("mis_rd", 32'h0000_0002, 32'hA5A5_A5A5, 1'b1, 1'b0);

        // Out-of-range store must not alias onto word 0.
        address      = 32'h0000_0400;
        write_data   = 32'hCAFE_F00D;
        write_enable = 1'b1;
        #1;
        check("oor_flag", {31'b0, out_of_range}, 32'd1);
        check("oor_rd", read_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        load_check("oor_w0", 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 1'b0);

        // Highest valid word and the edge just above it.
        store(32'h0000_03FC, 32'h7777_8888);
        load_check("top_w", 32'h0000_03FC, 32'h7777_8888, 1'b0, 1'b0);
        load_check("top_mis", 32'h0000_03FF, 32'h7777_8888, 1'b1, 1'b0);
        load_check("far_oor", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1);

        store(32'h0000_000D, 32'h5555_5555);
        load_check("mis_wr_w3", 32'h0000_000C, 32'h0000_0000, 1'b0, 1'b0);
`ifdef DMEM_ERR_COUNT_EN
        check("cnt_three", {16'b0, err_count}, 32'd3);
`endif

        // Read-during-write shows old data until the edge.
        store(32'h0000_000C, 32'h0000_0001);
        address      = 32'h0000_000C;
        write_data   = 32'h0000_0002;
        write_enable = 1'b1;
        #1;
        check("rdw_before", read_data, 32'h0000_0001);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("rdw_after", read_data, 32'h0000_0002);

        // Last of back-to-back stores wins.
        address      = 32'h0000_0010;
        write_data   = 32'hAAAA_AAAA;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_data   = 32'hBBBB_BBBB;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        load_check("b2b", 32'h0000_0010, 32'hBBBB_BBBB, 1'b0, 1'b0);

        // Reset coinciding with a store: clear wins.
        address      = 32'h0000_0008;
        write_data   = 32'h1111_2222;
        write_enable = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        write_enable = 1'b0;
        load_check("rstwr_w2", 32'h0000_0008, 32'h0000_0000, 1'b0, 1'b0);
        load_check("rstwr_w0", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        load_check("rstwr_top", 32'h0000_03FC, 32'h0000_0000, 1'b0, 1'b0);
`ifdef DMEM_ERR_COUNT_EN
        check("cnt_clr", {16'b0, err_count}, 32'd0);
`endif

        store(32'h0000_0014, 32'h0BAD_F00D);
        load_check("post_rst_wr", 32'h0000_0014, 32'h0BAD_F00D, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the 32-bit non-pipelined processor datapath; serves load/store instructions.
- Byte address in; 32-bit word out.
- Synchronous write on the rising clock edge; asynchronous (combinational) read.
- Flags misaligned and out-of-range accesses to the control/exception logic.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32, width of the byte address input.
- DATA_W, 32, word width; fixed at 32, other values are not supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  byte address; word index = address[log2(DEPTH_WORDS)+1:2].
- write_data  input  DATA_W  store data.
- write_enable  input  1  store strobe, sampled on the rising clk edge.
- read_data  output  DATA_W  load data; combinational from address and memory contents.
- misaligned  output  1  combinational; high when address[1:0] != 0.
- out_of_range  output  1  combinational; high when address >= 4*DEPTH_WORDS.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Storage: DEPTH_WORDS x 32-bit array.
- Reset:
  - Sampled high on a rising edge: every word is cleared to 0 in that same edge.
  - Any write presented in that cycle is discarded.
  - After reset, read_data = 0 for every in-range address.
  - Reset asserted mid-operation behaves the same: the clear wins over the write.
- Write:
  - Occurs at the rising edge when write_enable=1, reset=0, misaligned=0 and out_of_range=0.
  - mem[word index] <= write_data; all 32 bits are written, with no byte lanes.
- Suppressed writes:
  - write_enable=1 with misaligned or out_of_range high.
  - The memory is left unchanged and the flag remains visible for that cycle.
- Read:
  - read_data = mem[word index] combinationally, with zero-cycle latency.
  - No read enable; read_data is valid whenever address is stable.
  - address[1:0] is ignored for reads: a misaligned read returns the containing aligned word and raises misaligned.
  - An out_of_range read returns 32'h0.
- Read-during-write to the same word: read_data shows the old value until the rising edge and the new value immediately after. No write-first bypass.
- Back-to-back writes to the same word: the last write wins.
- Memory contents before the first reset are undefined (X in simulation). Reads after a reset or a write are defined.
- No handshake; single-cycle store and zero-latency load.

Optional Feature:
- Macro: DMEM_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [15:0].
  - Increments on each rising edge where write_enable=1 and the write is suppressed (misaligned or out_of_range).
  - Saturates at 16'hFFFF and clears to 0 on reset.
- Undefined:
  - Port and counter are absent.
  - Suppressed writes are dropped silently; flags still operate.

Test Plan:
- Write then read: write_enable=1, address=0x00, write_data=0x12345678, one edge; then write_enable=0, address=0x00 -> read_data=0x12345678.
- Untouched word after reset: reset pulse, then address=0x04, write_enable=0 -> read_data=0x00000000, flags low.
- Misaligned:
  - Write address=0x06, data=0xDEADBEEF -> misaligned=1, word 1 unchanged (read 0x04 -> 0x00000000).
  - Read 0x02 after a 0x00 write of 0xA5A5A5A5 -> 0xA5A5A5A5 with misaligned=1.
- Out of range: address=0x400 (DEPTH_WORDS=256), write 0xCAFEF00D -> out_of_range=1, read_data=0; word 0 is not aliased/overwritten.
- Reset mid-write: write_enable=1, reset=1, address=0x08, data=0x11112222 on the same edge -> read 0x08 = 0x00000000; earlier-written 0x00 also reads 0.
- Read-during-write: word 3 holds 0x1; set address=0x0C, write_data=0x2, write_enable=1 -> read_data=0x1 before the edge, 0x2 after. With DMEM_ERR_COUNT_EN, three suppressed writes -> err_count=3.
